// File: rtl/radix4_booth_multiplier_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// FSM state encodings and default operand/working-register widths.
package radix4_booth_multiplier_pkg;

  localparam int N     = 8;
  localparam int ANS_W = 2 * N + 2;
  localparam int ITER  = N / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to an addend select
// of 0, +/-M or +/-2M.
module booth_recoder (
  input  logic [2:0] trip,
  output logic       zero,
  output logic       neg,
  output logic       two
);

  always_comb begin
    zero = 1'b0;
    neg  = 1'b0;
    two  = 1'b0;
    case (trip)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         two  = 1'b1;
      3'b100: begin
        neg = 1'b1;
        two = 1'b1;
      end
      3'b101, 3'b110: neg = 1'b1;
      default:        zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/radix4_booth_multiplier.sv
// Sequential signed NxN multiplier, radix-4 Booth: one load cycle then N/2
// add/arithmetic-shift-by-2 iterations on the {A, Q, Qm1} working register.
module radix4_booth_multiplier
  import radix4_booth_multiplier_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [N-1:0]     mplier,
  input  logic [N-1:0]     mcand,
  output logic [1:0]       state,
  output logic [2*N+1:0]   ans,
  output logic             over
);

  localparam int AW = 2 * N + 2;
  localparam int IT = N / 2;
  localparam int CW = (IT > 1) ? $clog2(IT) : 1;

  state_t                state_q, state_d;
  logic [AW-1:0]         ans_q, ans_d;
  logic signed [N:0]     m_q, m_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  sel_zero, sel_neg, sel_two;
  logic signed [N+1:0]   mag, addend, sum;

  booth_recoder u_recoder (
    .trip (ans_q[2:0]),
    .zero (sel_zero),
    .neg  (sel_neg),
    .two  (sel_two)
  );

  // Addend in N+2 bits so that -2M with M = -2^(N-1) stays representable.
  always_comb begin
    mag    = sel_two ? {m_q, 1'b0} : {m_q[N], m_q};
    addend = sel_zero ? '0 : (sel_neg ? -mag : mag);
    sum    = {ans_q[AW-1], ans_q[AW-1:N+1]} + addend;
  end

  always_comb begin
    state_d = state_q;
    ans_d   = ans_q;
    m_d     = m_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          ans_d   = {{(N+1){1'b0}}, mplier, 1'b0};
          m_d     = {mcand[N-1], mcand};
          count_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        ans_d   = {sum[N+1], sum, ans_q[N:2]};
        count_d = count_q + 1'b1;
        if (count_q == CW'(IT - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ans_q   <= '0;
      m_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ans_q   <= ans_d;
      m_q     <= m_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign ans   = ans_q;
  assign over  = (state_q == S_DONE);

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Bench for radix4_booth_multiplier: directed corner products, control
// scenarios and randomized signed operands against an integer product model.
module tb_radix4_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  mplier = '0;
  logic [7:0]  mcand = '0;
  logic [1:0]  state;
  logic [17:0] ans;
  logic        over;

  int vectors = 0;
  int miscompares = 0;

  radix4_booth_multiplier #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .mplier (mplier),
    .mcand  (mcand),
    .state  (state),
    .ans    (ans),
    .over   (over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint product_of(input logic [17:0] a);
    logic signed [15:0] p;
    p = a[16:1];
    return longint'(p);
  endfunction

  // One full multiply; caller leaves go low beforehand. hold = extra DONE
  // cycles with go kept high; drop = release go right after the load edge.
  task automatic run_mul(input logic signed [7:0] a, input logic signed [7:0] b,
                         input bit scramble, input bit drop, input int hold);
    longint exp_p;
    exp_p = longint'(a) * longint'(b);
    @(negedge clk);
    mplier = a;
    mcand  = b;
    go     = 1'b1;
    check("st_idle", longint'(state), 0);
    @(posedge clk); #1;
    check("st_load", longint'(state), 1);
    @(negedge clk);
    if (scramble) begin
      mplier = 8'($urandom);
      mcand  = 8'($urandom);
    end
    if (drop) go = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("st_iter", longint'(state), (i < 4) ? 1 : 2);
      check("over_iter", longint'(over), (i < 4) ? 0 : 1);
    end
    check("product", product_of(ans), exp_p);
    check("sign", longint'(ans[17]), (exp_p < 0) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_prod", product_of(ans), exp_p);
      check("hold_over", longint'(over), 1);
    end
    if (!drop) begin
      @(negedge clk);
      go = 1'b0;
    end
    @(posedge clk); #1;
    check("st_ret", longint'(state), 0);
    check("over_ret", longint'(over), 0);
  endtask

  initial begin
    #12;
    check("rst_state", longint'(state), 0);
    check("rst_ans", longint'(ans), 0);
    check("rst_over", longint'(over), 0);
    @(negedge clk);
    rst = 1'b1;

    run_mul(8'sd120, 8'sd3, 1'b0, 1'b0, 10);
    run_mul(-8'sd128, -8'sd128, 1'b0, 1'b0, 0);
    run_mul(8'sd127, -8'sd128, 1'b0, 1'b0, 0);
    run_mul(-8'sd1, -8'sd1, 1'b0, 1'b0, 0);
    run_mul(8'sd0, 8'sd77, 1'b0, 1'b0, 0);
    run_mul(8'sd5, -8'sd7, 1'b1, 1'b0, 0);
    run_mul(-8'sd128, 8'sd127, 1'b0, 1'b1, 0);

    // Asynchronous abort in the middle of an operation.
    @(negedge clk);
    mplier = 8'd99;
    mcand  = 8'd45;
    go     = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_state", longint'(state), 0);
    check("abort_ans", longint'(ans), 0);
    check("abort_over", longint'(over), 0);
    @(negedge clk);
    go  = 1'b0;
    rst = 1'b1;
    run_mul(-8'sd13, 8'sd11, 1'b0, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      run_mul(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
